sdio_cmd_rx: RTL

Serial receiver for the SDIO CMD line on the card side. It detects the start bit, deserializes the 48-bit host command frame, and computes CRC7 serially over the first 40 bits. It checks the CRC, transmission bit and end bit, then presents the decoded command index and argument to the command decoder through a valid/ready handshake. It sits between the CMD pad sampler and the AXI-side command decoder.

---
 rtl/sdio_pkg.sv | 22 ++
 rtl/sdio_crc7_serial.sv | 28 ++
 rtl/sdio_cmd_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sdio_pkg.sv
// Shared SDIO command-path definitions: CRC7 polynomial, frame geometry,
// decoded frame layout and receiver state encoding.
package sdio_pkg;

  localparam logic [6:0] CRC7_POLY_DEFAULT = 7'h09;
  localparam int         CMD_FRAME_LEN     = 48;
  localparam int         CMD_CRC_START     = 40;

  // Frame bits 45:1 in transmission order: index, argument, CRC7.
  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    logic [6:0]  crc;
  } cmd_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } cmd_rx_state_t;

endpackage

// File: rtl/sdio_crc7_serial.sv
// Bit-serial CRC7 LFSR (SD form, x^7+x^3+1, init 0). One bit per enabled
// cycle, MSB of the message first; clr has priority over en. Shared by the
// command receiver and the response transmitter.
module sdio_crc7_serial #(
  parameter logic [6:0] POLY = 7'h09
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  // Feedback is the outgoing MSB xor the incoming bit, which yields the
  // standard SD CRC7 (e.g. CMD0 -> 7'h4A).
  assign fb = crc[6] ^ din;

  // LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= 7'h00;
    else if (clr) crc <= 7'h00;
    else if (en)  crc <= {crc[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
  end

endmodule

// File: rtl/sdio_cmd_rx.sv
// SDIO card-side CMD line receiver: start-bit detect, 48-bit deserialize,
// serial CRC7 over the first 40 bits, frame checks and a valid/ready
// output holding register with sticky overrun.
// Optional: define SDIO_CMD_RX_ERRCNT_EN to add the saturating crc_err_cnt.
module sdio_cmd_rx
  import sdio_pkg::*;
#(
  parameter int         FRAME_LEN = CMD_FRAME_LEN,
  parameter logic [6:0] CRC7_POLY = CRC7_POLY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        cmd_in,
  output logic        rx_busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        txbit_err,
  output logic        end_err,
`ifdef SDIO_CMD_RX_ERRCNT_EN
  output logic [7:0]  crc_err_cnt,
`endif
  output logic        overrun
);

  localparam logic [5:0] LAST_BIT  = 6'(FRAME_LEN - 1);
  localparam logic [5:0] CRC_START = 6'(CMD_CRC_START);

  cmd_rx_state_t state, state_nxt;
  logic [5:0]    count;
  // The start bit is always 0 and is never checked, so only frame bits
  // 46:0 are kept.
  logic [FRAME_LEN-2:0] shreg;
  logic [6:0]    crc_calc;
  cmd_frame_t    rx_frame;
  logic          shift_en, crc_en, crc_clr, done, load, drop, crc_bad, hs;

  assign rx_frame = cmd_frame_t'(shreg[45:1]);
  assign crc_bad  = (rx_frame.crc != crc_calc);
  assign hs       = cmd_valid && cmd_ready;

  sdio_crc7_serial #(.POLY(CRC7_POLY)) u_crc (
    .clk (clk),
    .rst (rst),
    .en  (crc_en),
    .clr (crc_clr),
    .din (cmd_in),
    .crc (crc_calc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bit_en && !cmd_in)           state_nxt = ST_RECV;
      ST_RECV: if (bit_en && count == LAST_BIT) state_nxt = ST_DONE;
      ST_DONE:                                  state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    rx_busy  = (state != ST_IDLE);
    shift_en = bit_en && ((state == ST_IDLE && !cmd_in) || state == ST_RECV);
    crc_en   = shift_en && (state == ST_IDLE || count < CRC_START);
    done     = (state == ST_DONE);
    crc_clr  = done;
    load     = done && (!cmd_valid || cmd_ready);
    drop     = done && cmd_valid && !cmd_ready;
  end

  // Bit counter and deserializer, MSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 6'd0;
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_LEN-3:0], cmd_in};
      count <= (state == ST_IDLE) ? 6'd1 : count + 6'd1;
    end else if (done) begin
      count <= 6'd0;
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
      crc_err   <= 1'b0;
      txbit_err <= 1'b0;
      end_err   <= 1'b0;
    end else if (load) begin
      cmd_valid <= 1'b1;
      cmd_index <= rx_frame.index;
      cmd_arg   <= rx_frame.arg;
      crc_err   <= crc_bad;
      txbit_err <= !shreg[46];
      end_err   <= !shreg[0];
    end else if (hs) begin
      cmd_valid <= 1'b0;
    end
  end

  // Sticky overrun: a completed frame found the holding register occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
    else if (hs)   overrun <= 1'b0;
  end

`ifdef SDIO_CMD_RX_ERRCNT_EN
  // Saturating CRC error counter, counts dropped frames too
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       crc_err_cnt <= 8'h00;
    else if (done && crc_bad && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'h01;
  end
`endif

endmodule
